ps2_rx_fifo: RTL and testbench
==============================

// Module: ps2_rx_fifo
// PURPOSE
//  Parametrised successor to the single-byte PS/2 Keyboard receiver. Synchronises PS/2 clk/data,
//  deframes start/data/odd-parity/stop, checks parity and framing, folds E0/F0 prefixes into
//  ext/brk flags, and buffers decoded keys in a FIFO with a valid/ready drain port.
//  Sits between the PS/2 pins and the game/control logic.
// PARAMETERS
//  DATA_W       8     data bits per frame, LSB first
//  FIFO_DEPTH   8     key entries buffered; power of 2, >=2
//  SYNC_STAGES  2     flops on i_ps2_clk and i_data, >=2
//  TIMEOUT_CYC  5000  i_clk cycles without a falling PS/2 edge before a mid-frame abort
//  PARITY_EN    1     1: odd parity enforced; 0: parity bit ignored
// PORTS
//  i_clk        in   1                    system clock, 50 MHz
//  i_rst        in   1                    synchronous, active-high reset
//  i_ps2_clk    in   1                    raw PS/2 clock, asynchronous
//  i_data       in   1                    raw PS/2 data, asynchronous
//  i_ready      in   1                    consumer accepts head entry
//  o_valid      out  1                    FIFO non-empty
//  o_data       out  DATA_W               head scan code; 0 when o_valid=0
//  o_ext        out  1                    head entry preceded by E0
//  o_brk        out  1                    head entry preceded by F0 (key release)
//  o_count      out  $clog2(FIFO_DEPTH)+1 entries held
//  o_err_parity out  1                    1-cycle pulse: parity failure
//  o_err_frame  out  1                    1-cycle pulse: start!=0 or stop!=1
//  o_timeout    out  1                    1-cycle pulse: mid-frame abort
//  o_overflow   out  1                    1-cycle pulse: good key dropped, FIFO full
// BEHAVIOUR
//  - Reset: all outputs 0, FIFO empty, state IDLE, ext/brk flags 0, synchronisers loaded with 1.
//  - Edge: fall = sync_clk_q & ~sync_clk; data bit = synchronised i_data in that same cycle.
//  - FSM (advances only on fall): IDLE -(bit=0)-> DATA; IDLE -(bit=1)-> IDLE and o_err_frame.
//    DATA: shift in DATA_W bits, LSB first -> PARITY -> STOP -> IDLE.
//  - At STOP, checked in this order: stop!=1 -> o_err_frame; else parity bad with PARITY_EN
//    -> o_err_parity; else byte good. Errored byte is discarded; ext/brk flags kept.
//  - Good byte (DATA_W=8): E0 sets ext, F0 sets brk; neither is pushed. Any other byte is pushed
//    as {brk,ext,data}, then both flags clear.
//  - DATA_W!=8: prefix decode disabled; every good byte pushed with ext=brk=0.
//  - Latency: push in the cycle after the stop-bit fall; o_valid rises the cycle after the push.
//  - Timeout: counter clears on every fall and is held at 0 in IDLE. At TIMEOUT_CYC -> IDLE,
//    partial frame discarded, o_timeout pulse. Flags kept.
//  - Drain is FWFT: pop when o_valid & i_ready; o_data/o_ext/o_brk show the new head next cycle.
//  - Full: a push with no pop is dropped with o_overflow. Push and pop in the same cycle while
//    full are both accepted and count is unchanged. i_ready with FIFO empty is ignored.
//  - Pointers wrap modulo FIFO_DEPTH. o_count = FIFO_DEPTH exactly when full.
//  - Mid-operation reset: partial frame lost, FIFO flushed. Next full frame decodes normally.
// STRUCTURE
//  - ps2_pkg: state enum {IDLE,DATA,PARITY,STOP}, PS2_EXT=8'hE0, PS2_BRK=8'hF0,
//    packed struct key_t {brk, ext, data}.
//  - Sub-module ps2_sync_fifo (#WIDTH,#DEPTH): push/pop/full/empty/count, FWFT, sync reset.
//  - Top level holds the synchronisers, edge detect, FSM, timeout counter and prefix flags.
// TESTING (50 MHz i_clk, PS/2 half-period 100 ns)
//  1 Frame 0x1C, parity 0 -> o_valid, o_data=0x1C, ext=0, brk=0; i_ready pop -> o_valid=0, o_count=0.
//  2 Frames E0,F0,75 -> one entry: data=0x75, ext=1, brk=1; next frame 0x75 -> ext=0, brk=0.
//  3 Frame 0x1C, parity 1 -> single o_err_parity pulse, no push; following 0x29 accepted.
//  4 Start bit plus 4 data bits, then idle TIMEOUT_CYC+1 cycles -> one o_timeout pulse;
//    then frame 0x29 -> o_data=0x29.
//  5 i_ready=0, frames 0x01..0x08 -> o_count=8. Frame 0x09 -> o_overflow, count stays 8.
//    Drain yields 0x01..0x08 in order. Pop during push at full -> count stays 8.
//  6 i_rst=1 for 2 cycles after the 5th data bit -> all outputs 0; next frame 0x1C received cleanly.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types for the PS/2 keyboard receiver: deframer states, prefix codes, key entry layout.
package ps2_pkg;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_state_e;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  // Entry layout for the standard 8-bit scan-code build; the top packs {brk, ext, data} the same way.
  typedef struct packed {
    logic       brk;
    logic       ext;
    logic [7:0] data;
  } key_t;

endpackage

// File: rtl/ps2_sync_fifo.sv
// First-word-fall-through FIFO with synchronous reset; head entry is visible on rdata while non-empty.
module ps2_sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      cnt;
  logic             do_push, do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A pop frees the slot this same cycle, so a push at full is still taken.
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];
  assign count   = cnt;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver: synchronise pins, deframe and check each byte, fold E0/F0 prefixes
// into ext/brk flags, and queue decoded keys behind a valid/ready drain port.
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int FIFO_DEPTH  = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 5000,
  parameter int PARITY_EN   = 1
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_ps2_clk,
  input  logic                          i_data,
  input  logic                          i_ready,
  output logic                          o_valid,
  output logic [DATA_W-1:0]             o_data,
  output logic                          o_ext,
  output logic                          o_brk,
  output logic [$clog2(FIFO_DEPTH):0]   o_count,
  output logic                          o_err_parity,
  output logic                          o_err_frame,
  output logic                          o_timeout,
  output logic                          o_overflow
);

  localparam int BIT_W = $clog2(DATA_W + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);
  localparam int KEY_W = DATA_W + 2;

  logic [SYNC_STAGES-1:0] clk_sync, dat_sync;
  logic                   sync_clk_q, sync_clk, ps2_bit, fall;

  ps2_state_e             state, state_n;
  logic [DATA_W-1:0]      shreg;
  logic [BIT_W-1:0]       bit_cnt;
  logic                   par_bit;
  logic [TO_W-1:0]        to_cnt;
  logic                   ext_flag, brk_flag;
  logic                   push_q;
  logic [KEY_W-1:0]       push_key;

  logic                   to_hit, err_start, frame_done, stop_bad, par_bad, byte_good;
  logic                   is_ext, is_brk;

  logic [KEY_W-1:0]       head;
  logic                   fifo_full, fifo_empty, pop;

  // Synchronisers idle high, matching the released PS/2 bus, so reset never fakes a falling edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      clk_sync   <= '1;
      dat_sync   <= '1;
      sync_clk_q <= 1'b1;
    end else begin
      clk_sync   <= {clk_sync[SYNC_STAGES-2:0], i_ps2_clk};
      dat_sync   <= {dat_sync[SYNC_STAGES-2:0], i_data};
      sync_clk_q <= clk_sync[SYNC_STAGES-1];
    end
  end

  assign sync_clk = clk_sync[SYNC_STAGES-1];
  assign ps2_bit  = dat_sync[SYNC_STAGES-1];
  assign fall     = sync_clk_q & ~sync_clk;

  assign stop_bad  = ~ps2_bit;
  assign par_bad   = (PARITY_EN != 0) && !(^{shreg, par_bit});
  assign is_ext    = (DATA_W == 8) && (shreg == DATA_W'(PS2_EXT));
  assign is_brk    = (DATA_W == 8) && (shreg == DATA_W'(PS2_BRK));
  assign byte_good = frame_done & ~stop_bad & ~par_bad;

  always_comb begin
    state_n    = state;
    err_start  = 1'b0;
    frame_done = 1'b0;
    to_hit     = (state != IDLE) && !fall && (to_cnt == TO_W'(TIMEOUT_CYC - 1));
    if (to_hit) begin
      state_n = IDLE;
    end else if (fall) begin
      case (state)
        IDLE:    if (!ps2_bit) state_n = DATA; else err_start = 1'b1;
        DATA:    if (bit_cnt == BIT_W'(DATA_W - 1)) state_n = PARITY;
        PARITY:  state_n = STOP;
        STOP:    begin state_n = IDLE; frame_done = 1'b1; end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= IDLE;
      shreg        <= '0;
      bit_cnt      <= '0;
      par_bit      <= 1'b0;
      to_cnt       <= '0;
      ext_flag     <= 1'b0;
      brk_flag     <= 1'b0;
      push_q       <= 1'b0;
      push_key     <= '0;
      o_err_frame  <= 1'b0;
      o_err_parity <= 1'b0;
      o_timeout    <= 1'b0;
    end else begin
      state        <= state_n;
      o_err_frame  <= err_start | (frame_done & stop_bad);
      o_err_parity <= frame_done & ~stop_bad & par_bad;
      o_timeout    <= to_hit;
      push_q       <= 1'b0;

      if (state == IDLE || fall || to_hit) to_cnt <= '0;
      else                                 to_cnt <= to_cnt + 1'b1;

      if (fall && !to_hit) begin
        case (state)
          IDLE:    bit_cnt <= '0;
          DATA:    begin
                     shreg   <= {ps2_bit, shreg[DATA_W-1:1]};
                     bit_cnt <= bit_cnt + 1'b1;
                   end
          PARITY:  par_bit <= ps2_bit;
          default: ;
        endcase
      end

      // Prefixes only arm the flags; the next ordinary byte carries and consumes them.
      if (byte_good) begin
        if (is_ext)      ext_flag <= 1'b1;
        else if (is_brk) brk_flag <= 1'b1;
        else begin
          push_q   <= 1'b1;
          push_key <= {brk_flag, ext_flag, shreg};
          ext_flag <= 1'b0;
          brk_flag <= 1'b0;
        end
      end
    end
  end

  assign pop = o_valid & i_ready;

  ps2_sync_fifo #(.WIDTH(KEY_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (i_clk),
    .rst   (i_rst),
    .push  (push_q),
    .wdata (push_key),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (o_count)
  );

  // FIFO storage is not reset, so the head fields are masked while empty.
  assign o_valid    = ~fifo_empty;
  assign o_data     = o_valid ? head[DATA_W-1:0] : '0;
  assign o_ext      = o_valid & head[DATA_W];
  assign o_brk      = o_valid & head[DATA_W+1];
  assign o_overflow = push_q & fifo_full & ~pop;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Bench for ps2_rx_fifo: directed scenarios plus randomized frames against a queue-based key model.
`timescale 1ns/1ps
module tb_ps2_rx_fifo;
  import ps2_pkg::*;

  localparam int DEPTH = 8;
  localparam int TO    = 5000;

  logic       i_clk = 1'b0, i_rst = 1'b1, i_ps2_clk = 1'b1, i_data = 1'b1, i_ready = 1'b0;
  logic       o_valid, o_ext, o_brk, o_err_parity, o_err_frame, o_timeout, o_overflow;
  logic [7:0] o_data;
  logic [3:0] o_count;

  ps2_rx_fifo #(
    .DATA_W(8), .FIFO_DEPTH(DEPTH), .SYNC_STAGES(2), .TIMEOUT_CYC(TO), .PARITY_EN(1)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_ps2_clk(i_ps2_clk), .i_data(i_data), .i_ready(i_ready),
    .o_valid(o_valid), .o_data(o_data), .o_ext(o_ext), .o_brk(o_brk), .o_count(o_count),
    .o_err_parity(o_err_parity), .o_err_frame(o_err_frame), .o_timeout(o_timeout),
    .o_overflow(o_overflow)
  );

  always #10 i_clk = ~i_clk;

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Observed pulse cycles
  int seen_par = 0, seen_frm = 0, seen_to = 0, seen_ovf = 0;
  always @(negedge i_clk) if (!i_rst) begin
    seen_par += int'(o_err_parity);
    seen_frm += int'(o_err_frame);
    seen_to  += int'(o_timeout);
    seen_ovf += int'(o_overflow);
  end

  // Reference model: decoded keys in arrival order, pending prefix flags, expected event counts
  key_t mq[$];
  bit   m_ext = 0, m_brk = 0;
  int   exp_par = 0, exp_frm = 0, exp_to = 0, exp_ovf = 0;

  function automatic void model_byte(input logic [7:0] d, input bit par_bad, input bit stop_bad);
    key_t k;
    if (stop_bad)           exp_frm++;
    else if (par_bad)       exp_par++;
    else if (d == 8'hE0)    m_ext = 1;
    else if (d == 8'hF0)    m_brk = 1;
    else begin
      if (mq.size() >= DEPTH) exp_ovf++;
      else begin
        k.brk = m_brk; k.ext = m_ext; k.data = d;
        mq.push_back(k);
      end
      m_ext = 0; m_brk = 0;
    end
  endfunction

  // Drives n bits LSB first, ~100 ns per PS/2 half period; optionally pulses i_ready so the
  // pop lands in the cycle the final byte is pushed (3rd i_clk edge after the raw fall).
  task automatic send_bits(input logic [10:0] bits, input int n, input bit pop_at_end);
    for (int i = 0; i < n; i++) begin
      i_data = bits[i];
      repeat (5) @(negedge i_clk);
      i_ps2_clk = 1'b0;
      for (int c = 1; c <= 5; c++) begin
        @(posedge i_clk);
        if (pop_at_end && i == n-1) begin
          if (c == 3) #1 i_ready = 1'b1;
          else if (c == 4) #1 i_ready = 1'b0;
        end
      end
      @(negedge i_clk);
      i_ps2_clk = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input bit par_bad, input bit stop_bad,
                            input bit pop_at_end);
    logic p;
    p = (~^d) ^ par_bad;
    send_bits({~stop_bad, p, d, 1'b0}, 11, pop_at_end);
    model_byte(d, par_bad, stop_bad);
  endtask

  task automatic check_pulses(input string tag);
    repeat (4) @(negedge i_clk);
    chk({tag, "_par"}, seen_par, exp_par);
    chk({tag, "_frm"}, seen_frm, exp_frm);
    chk({tag, "_to"},  seen_to,  exp_to);
    chk({tag, "_ovf"}, seen_ovf, exp_ovf);
  endtask

  task automatic drain(input string tag);
    key_t k;
    repeat (4) @(negedge i_clk);
    chk({tag, "_count"}, o_count, mq.size());
    for (int g = 0; g < DEPTH + 2; g++) begin
      @(negedge i_clk);
      if (mq.size() == 0) break;
      k = mq.pop_front();
      chk({tag, "_valid"}, o_valid, 1);
      chk({tag, "_data"},  o_data,  k.data);
      chk({tag, "_ext"},   o_ext,   k.ext);
      chk({tag, "_brk"},   o_brk,   k.brk);
      i_ready = 1'b1;
      @(posedge i_clk);
      #1 i_ready = 1'b0;
    end
    @(negedge i_clk);
    chk({tag, "_empty_valid"}, o_valid, 0);
    chk({tag, "_empty_count"}, o_count, 0);
    chk({tag, "_empty_data"},  o_data,  0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_valid"}, o_valid, 0);
    chk({tag, "_data"},  o_data,  0);
    chk({tag, "_count"}, o_count, 0);
    chk({tag, "_flags"}, {o_ext, o_brk, o_err_parity, o_err_frame, o_timeout, o_overflow}, 0);
  endtask

  initial begin
    int  nf;
    logic [7:0] d;
    bit  pb, sb;

    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    check_all_zero("reset");
    i_rst = 1'b0;
    repeat (3) @(negedge i_clk);

    // Plain key, then pop
    send_frame(8'h1C, 0, 0, 0);
    drain("t1");

    // Extended release, then the same key with flags cleared
    send_frame(8'hE0, 0, 0, 0);
    send_frame(8'hF0, 0, 0, 0);
    send_frame(8'h75, 0, 0, 0);
    send_frame(8'h75, 0, 0, 0);
    drain("t2");

    // Bad parity discarded, next byte fine
    send_frame(8'h1C, 1, 0, 0);
    send_frame(8'h29, 0, 0, 0);
    drain("t3");
    check_pulses("t3");

    // Start bit of 1 and stop bit of 0 are framing errors
    send_bits(11'h001, 1, 0);
    exp_frm++;
    send_frame(8'h33, 0, 1, 0);
    check_pulses("frm");

    // Mid-frame abort after start + 4 data bits
    send_bits({2'b11, 8'h5A, 1'b0}, 5, 0);
    exp_to++;
    repeat (TO + 20) @(negedge i_clk);
    send_frame(8'h29, 0, 0, 0);
    drain("t4");
    check_pulses("t4");

    // Fill, overflow, then pop coinciding with a push at full
    for (int i = 1; i <= DEPTH; i++) send_frame(8'(i), 0, 0, 0);
    repeat (4) @(negedge i_clk);
    chk("t5_full_count", o_count, DEPTH);
    send_frame(8'h09, 0, 0, 0);
    repeat (4) @(negedge i_clk);
    chk("t5_ovf_count", o_count, DEPTH);
    check_pulses("t5a");
    void'(mq.pop_front());
    send_frame(8'h0A, 0, 0, 1);
    repeat (4) @(negedge i_clk);
    chk("t5_poppush_count", o_count, DEPTH);
    check_pulses("t5b");
    drain("t5");

    // Reset mid-frame flushes queued keys and pending prefix
    send_frame(8'h1C, 0, 0, 0);
    send_frame(8'hE0, 0, 0, 0);
    send_bits({2'b11, 8'h44, 1'b0}, 6, 0);
    repeat (3) @(negedge i_clk);
    i_rst = 1'b1;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    check_all_zero("t6_rst");
    i_rst = 1'b0;
    mq.delete();
    m_ext = 0; m_brk = 0;
    repeat (3) @(negedge i_clk);
    send_frame(8'h1C, 0, 0, 0);
    drain("t6");
    check_pulses("t6");

    // Randomized chunks; chunk sizes may exceed the FIFO to exercise overflow
    for (int ch = 0; ch < 5; ch++) begin
      nf = int'($urandom_range(1, 11));
      for (int f = 0; f < nf; f++) begin
        case ($urandom_range(0, 5))
          0:       d = 8'hE0;
          1:       d = 8'hF0;
          default: d = 8'($urandom_range(0, 255));
        endcase
        pb = ($urandom_range(0, 9) == 0);
        sb = ($urandom_range(0, 19) == 0);
        send_frame(d, pb, sb, 0);
      end
      drain("rnd");
      check_pulses("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #20ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
